// File: rtl/aes_cipher_feeder_pkg.sv
//------------------------------------------------------------------------------
// Module : aes_pkg
// Brief  : Shared types, write-address map and word-select helper for the
//          AES-128 cipher feeder.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2
  } feeder_state_e;

  localparam logic [2:0] ADDR_DATA0 = 3'd0;
  localparam logic [2:0] ADDR_KEY0  = 3'd4;

  // Word 0 is the most significant word, matching the write map.
  function automatic logic [31:0] word_of(input aes_block_t blk, input logic [1:0] sel);
    logic [31:0] w;
    case (sel)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_cipher_feeder_if.sv
//------------------------------------------------------------------------------
// Module : aes_cipher_feeder_if
// Brief  : Core-side register bus plus cipher-side signals of the AES feeder.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface aes_cipher_feeder_if;
  import aes_pkg::*;

  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [31:0]      wr_data;
  logic             start_req;
  logic [1:0]       rd_sel;
  logic [31:0]      rd_data;
  logic             busy;
  logic             done;
  logic             result_valid;
  logic             err;
  logic             cipher_start;
  aes_block_t       cipher_datain;
  aes_block_t       cipher_key;
  aes_block_t       cipher_dataout;

  modport slave (
    input  wr_en, wr_addr, wr_data, start_req, rd_sel, cipher_dataout,
    output rd_data, busy, done, result_valid, err,
           cipher_start, cipher_datain, cipher_key
  );

  modport master (
    output wr_en, wr_addr, wr_data, start_req, rd_sel, cipher_dataout,
    input  rd_data, busy, done, result_valid, err,
           cipher_start, cipher_datain, cipher_key
  );

endinterface

`default_nettype wire

// File: rtl/aes_cipher_feeder_word_packer.sv
//------------------------------------------------------------------------------
// Module : aes_word_packer
// Brief  : Four 32-bit words assembled into one 128-bit block with a valid
//          bit per word; word 0 lands in bits [127:96].
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module aes_word_packer
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en_i,
  input  logic [1:0]  wr_idx_i,
  input  logic [31:0] wr_data_i,
  input  logic        clr_valid_i,
  output aes_block_t  block_o,
  output logic [3:0]  valid_o
);

  aes_block_t block_q, block_d;
  logic [3:0] valid_q, valid_d;

  // A write in the same cycle as a clear keeps its own valid bit.
  always_comb begin
    block_d = block_q;
    valid_d = valid_q;
    if (clr_valid_i) valid_d = 4'h0;
    if (wr_en_i) begin
      valid_d[wr_idx_i] = 1'b1;
      case (wr_idx_i)
        2'd0:    block_d[127:96] = wr_data_i;
        2'd1:    block_d[95:64]  = wr_data_i;
        2'd2:    block_d[63:32]  = wr_data_i;
        default: block_d[31:0]   = wr_data_i;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      block_q <= '0;
      valid_q <= 4'h0;
    end else begin
      block_q <= block_d;
      valid_q <= valid_d;
    end
  end

  assign block_o = block_q;
  assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/aes_cipher_feeder.sv
//------------------------------------------------------------------------------
// Module : aes_cipher_feeder
// Brief  : Collects plaintext/key words from the core, launches the pipelined
//          AES-128 core, waits out its latency and returns the ciphertext.
//          Build option AES_KEY_REUSE_EN keeps the key valid across blocks.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module aes_cipher_feeder
  import aes_pkg::*;
#(
  parameter int unsigned CIPHER_LAT = 10,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                clk,
  input  logic                rst,
  aes_cipher_feeder_if.slave  bus
);

  feeder_state_e    state_q;
  logic [CNT_W-1:0] cnt_q;
  aes_block_t       result_q;
  logic             result_valid_q;
  logic             done_q;
  logic             err_q;
  logic             busy_q;
  logic             cipher_start_q;

  aes_block_t       data_blk;
  aes_block_t       key_blk;
  logic [3:0]       data_valid;
  logic [3:0]       key_valid;
  logic [7:0]       valid_mask;
  logic [7:0]       mask_eff;
  logic             wr_ok;
  logic             finish;
  logic             key_clr;

  assign wr_ok      = bus.wr_en && (state_q == IDLE);
  assign finish     = (state_q == RUN) && (cnt_q == '0);
  assign valid_mask = {key_valid, data_valid};
  // A write landing with start_req already counts toward the mask check.
  assign mask_eff   = valid_mask | (wr_ok ? (8'h01 << bus.wr_addr) : 8'h00);

`ifdef AES_KEY_REUSE_EN
  assign key_clr = 1'b0;
`else
  assign key_clr = finish;
`endif

  aes_word_packer u_data_packer (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (wr_ok && (bus.wr_addr < ADDR_KEY0)),
    .wr_idx_i    (bus.wr_addr[1:0]),
    .wr_data_i   (bus.wr_data),
    .clr_valid_i (finish),
    .block_o     (data_blk),
    .valid_o     (data_valid)
  );

  aes_word_packer u_key_packer (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (wr_ok && (bus.wr_addr >= ADDR_KEY0)),
    .wr_idx_i    (bus.wr_addr[1:0]),
    .wr_data_i   (bus.wr_data),
    .clr_valid_i (key_clr),
    .block_o     (key_blk),
    .valid_o     (key_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
      cipher_start_q <= 1'b0;
    end else begin
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      cipher_start_q <= 1'b0;
      if (wr_ok) result_valid_q <= 1'b0;
      if (bus.wr_en && (state_q != IDLE)) err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (bus.start_req) begin
            if (mask_eff == 8'hFF) begin
              state_q        <= ISSUE;
              busy_q         <= 1'b1;
              cipher_start_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          cnt_q   <= CNT_W'(CIPHER_LAT - 1);
          state_q <= RUN;
        end
        RUN: begin
          if (cnt_q == '0) begin
            result_q       <= bus.cipher_dataout;
            result_valid_q <= 1'b1;
            done_q         <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rd_data       = word_of(result_q, bus.rd_sel);
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.result_valid  = result_valid_q;
  assign bus.err           = err_q;
  assign bus.cipher_start  = cipher_start_q;
  assign bus.cipher_datain = data_blk;
  assign bus.cipher_key    = key_blk;

endmodule

`default_nettype wire

// File: tb/tb_aes_cipher_feeder.sv
//------------------------------------------------------------------------------
// Module : tb_aes_cipher_feeder
// Brief  : Bench for aes_cipher_feeder with a behavioural 10-stage AES-128
//          pipeline behind it and a ciphertext scoreboard.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_aes_cipher_feeder;
  import aes_pkg::*;

  localparam int CIPHER_LAT = 10;

  localparam aes_block_t KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam aes_block_t PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam aes_block_t CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam aes_block_t KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam aes_block_t PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam aes_block_t CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_cipher_feeder_if bus();

  aes_cipher_feeder #(.CIPHER_LAT(CIPHER_LAT), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cs_count     = 0;
  aes_block_t sb_q[$];

  // ---------------- behavioural AES-128 ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    for (int c = 1; c < 256; c++)
      if (gmul(a, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic aes_block_t aes_encrypt(input aes_block_t pt, input aes_block_t key);
    logic [31:0] w[44];
    logic [7:0]  st[16];
    logic [7:0]  tmp[16];
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [31:0] t;
    aes_block_t  rk, res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) st[i] = sbox(st[i]);
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) tmp[4*c+rr] = st[4*((c+rr)%4)+rr];
      for (int i = 0; i < 16; i++) st[i] = tmp[i];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  // Output is only non-zero in the cycle the launched block emerges.
  aes_block_t pipe_d[CIPHER_LAT];
  logic       pipe_v[CIPHER_LAT] = '{default: 1'b0};

  always @(posedge clk) begin
    pipe_v[0] <= bus.cipher_start;
    if (bus.cipher_start) pipe_d[0] <= aes_encrypt(bus.cipher_datain, bus.cipher_key);
    else                  pipe_d[0] <= '0;
    for (int i = 1; i < CIPHER_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
    if (bus.cipher_start) cs_count <= cs_count + 1;
  end

  assign bus.cipher_dataout = pipe_v[CIPHER_LAT-1] ? pipe_d[CIPHER_LAT-1] : '0;

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [2:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    cyc();
    bus.wr_en   = 1'b0;
  endtask

  task automatic load(input aes_block_t key, input aes_block_t pt);
    for (int i = 0; i < 4; i++) write_word(3'(i), pt[127-32*i -: 32]);
    for (int i = 0; i < 4; i++) write_word(3'(4 + i), key[127-32*i -: 32]);
  endtask

  task automatic read_result(output aes_block_t r);
    for (int i = 0; i < 4; i++) begin
      bus.rd_sel = 2'(i);
      #1;
      r[127-32*i -: 32] = bus.rd_data;
    end
  endtask

  // Caller raises start_req; n counts cycles from that cycle to done.
  task automatic wait_done(output bit seen, output int n);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 40) begin
      cyc();
      n++;
      if (n == 1) bus.start_req = 1'b0;
      seen = bus.done;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start_req = 1'b0; bus.rd_sel = '0;
    repeat (3) cyc();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] w;
    do_reset();
    tests_run++;
    if ({bus.busy, bus.done, bus.err, bus.result_valid, bus.cipher_start} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 00000",
               {bus.busy, bus.done, bus.err, bus.result_valid, bus.cipher_start});
    end
    tests_run++;
    if (bus.cipher_datain !== '0 || bus.cipher_key !== '0) begin
      tests_failed++;
      $display("FAIL reset_regs: datain %h key %h expected 0", bus.cipher_datain, bus.cipher_key);
    end
    for (int i = 0; i < 4; i++) begin
      bus.rd_sel = 2'(i);
      #1;
      w = bus.rd_data;
      tests_run++;
      if (w !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_rd%0d: got %h expected 00000000", i, w);
      end
    end
  endtask

  task automatic test_fips_c1();
    bit seen; int n; int cs0; aes_block_t exp, r;
    load(KEY_C1, PT_C1);
    cs0 = cs_count;
    bus.start_req = 1'b1;
    sb_q.push_back(CT_C1);
    wait_done(seen, n);
    exp = sb_q.pop_front();
    tests_run++;
    if (!seen || n != CIPHER_LAT + 2) begin
      tests_failed++;
      $display("FAIL c1_latency: done seen=%0d after %0d cycles expected %0d", seen, n, CIPHER_LAT + 2);
    end
    read_result(r);
    tests_run++;
    if (r !== exp) begin
      tests_failed++;
      $display("FAIL c1_result: got %h expected %h", r, exp);
    end
    tests_run++;
    if (bus.result_valid !== 1'b1 || bus.busy !== 1'b0 || cs_count - cs0 != 1) begin
      tests_failed++;
      $display("FAIL c1_status: valid %b busy %b starts %0d expected 1 0 1",
               bus.result_valid, bus.busy, cs_count - cs0);
    end
  endtask

  task automatic test_fips_b();
    bit seen; int n; aes_block_t exp;
    load(KEY_B, PT_B);
    tests_run++;
    if (bus.result_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b_valid_clear: got %b expected 0", bus.result_valid);
    end
    bus.start_req = 1'b1;
    sb_q.push_back(CT_B);
    wait_done(seen, n);
    exp = sb_q.pop_front();
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL b_timeout: done not seen after %0d cycles", n);
    end
    for (int i = 0; i < 4; i++) begin
      bus.rd_sel = 2'(i);
      #1;
      tests_run++;
      if (bus.rd_data !== exp[127-32*i -: 32]) begin
        tests_failed++;
        $display("FAIL b_word%0d: got %h expected %h", i, bus.rd_data, exp[127-32*i -: 32]);
      end
    end
  endtask

  task automatic test_incomplete_mask();
    int cs0;
    do_reset();
    for (int i = 0; i < 4; i++) write_word(3'(i), PT_C1[127-32*i -: 32]);
    for (int i = 0; i < 3; i++) write_word(3'(4 + i), KEY_C1[127-32*i -: 32]);
    cs0 = cs_count;
    bus.start_req = 1'b1;
    cyc();
    bus.start_req = 1'b0;
    tests_run++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mask_err: err %b busy %b expected 1 0", bus.err, bus.busy);
    end
    cyc();
    tests_run++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mask_err_pulse: err %b busy %b expected 0 0", bus.err, bus.busy);
    end
    repeat (3) cyc();
    tests_run++;
    if (cs_count != cs0) begin
      tests_failed++;
      $display("FAIL mask_no_start: cipher starts %0d expected 0", cs_count - cs0);
    end
  endtask

  task automatic test_write_during_run();
    bit seen; int n; aes_block_t exp, r;
    load(KEY_C1, PT_C1);
    bus.start_req = 1'b1;
    sb_q.push_back(CT_C1);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      cyc();
      n++;
      if (n == 1) bus.start_req = 1'b0;
      if (n == 6) begin
        bus.wr_en = 1'b0;
        tests_run++;
        if (bus.err !== 1'b1 || bus.cipher_datain !== PT_C1) begin
          tests_failed++;
          $display("FAIL run_write: err %b datain %h expected 1 %h", bus.err, bus.cipher_datain, PT_C1);
        end
      end
      seen = bus.done;
      if (n == 5) begin
        bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 32'hdeadbeef;
      end
    end
    exp = sb_q.pop_front();
    read_result(r);
    tests_run++;
    if (!seen || n != CIPHER_LAT + 2 || r !== exp) begin
      tests_failed++;
      $display("FAIL run_write_result: seen %0d lat %0d got %h expected %h", seen, n, r, exp);
    end
  endtask

  task automatic test_rst_mid_run();
    bit seen; int n; int dones; aes_block_t exp, r;
    load(KEY_B, PT_B);
    bus.start_req = 1'b1;
    cyc();
    bus.start_req = 1'b0;
    repeat (5) cyc();   // now in the RUN cycle with cnt == 5
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cipher_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_abort: busy %b done %b start %b expected 0 0 0",
               bus.busy, bus.done, bus.cipher_start);
    end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (bus.done) dones++;
    end
    tests_run++;
    if (dones != 0) begin
      tests_failed++;
      $display("FAIL rst_no_done: done pulses %0d expected 0", dones);
    end
    bus.start_req = 1'b1;
    cyc();
    bus.start_req = 1'b0;
    tests_run++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mask_cleared: err %b busy %b expected 1 0", bus.err, bus.busy);
    end
    load(KEY_B, PT_B);
    bus.start_req = 1'b1;
    sb_q.push_back(CT_B);
    wait_done(seen, n);
    exp = sb_q.pop_front();
    read_result(r);
    tests_run++;
    if (!seen || r !== exp) begin
      tests_failed++;
      $display("FAIL rst_rerun: seen %0d got %h expected %h", seen, r, exp);
    end
  endtask

  task automatic test_back_to_back();
`ifdef AES_KEY_REUSE_EN
    bit seen; int n; aes_block_t exp, r;
`endif
    for (int i = 0; i < 4; i++) write_word(3'(i), PT_B[127-32*i -: 32]);
    tests_run++;
    if (bus.result_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reuse_valid_clear: got %b expected 0", bus.result_valid);
    end
    bus.start_req = 1'b1;
`ifdef AES_KEY_REUSE_EN
    sb_q.push_back(CT_B);
    wait_done(seen, n);
    exp = sb_q.pop_front();
    read_result(r);
    tests_run++;
    if (!seen || n != CIPHER_LAT + 2 || r !== exp) begin
      tests_failed++;
      $display("FAIL reuse_result: seen %0d lat %0d got %h expected %h", seen, n, r, exp);
    end
`else
    cyc();
    bus.start_req = 1'b0;
    tests_run++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reuse_err: err %b busy %b expected 1 0", bus.err, bus.busy);
    end
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_incomplete_mask();
    test_write_during_run();
    test_rst_mid_run();
    test_back_to_back();
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
